// File: rtl/tick_divider_pkg.sv
// tick_divider_pkg: shared constants and helpers
// for the multi-channel tick/clock divider.
package tick_divider_pkg;

  localparam int unsigned DEF_PERIOD = 500000;
  localparam int unsigned DEF_HIGH   = 250000;
  localparam int unsigned MIN_PERIOD = 2;

  // Periods below MIN_PERIOD would make the wrap
  // compare degenerate, so they are raised to it.
  function automatic logic [31:0] clamp_period(
    input logic [31:0] p
  );
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/tick_divider_ch.sv
// tick_divider_ch: one divider channel. Counter,
// active/shadow period+high, pending flag, and the
// registered clk_o/tick_o outputs.
// Ports: clk, rst_n (async low), en_i, sync_i,
//   wr_i + period_i/high_i (shadow load),
//   pend_o, clk_o, tick_o.
module tick_divider_ch
  import tick_divider_pkg::*;
#(
  parameter int          CNT_W = 19,
  parameter int unsigned DEF_P = DEF_PERIOD,
  parameter int unsigned DEF_H = DEF_HIGH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] high_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] RST_P =
    CNT_W'(clamp_period(DEF_P));
  localparam logic [CNT_W-1:0] RST_H =
    CNT_W'(DEF_H);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] sper_q, sper_d;
  logic [CNT_W-1:0] shigh_q, shigh_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             last;
  logic             apply;

  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    high_d  = high_q;
    sper_d  = sper_q;
    shigh_d = shigh_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    apply   = 1'b0;
    // per_q never drops below 2, no underflow
    last    = (cnt_q == per_q - ONE);

    if (sync_i) begin
      cnt_d = '0;
      apply = pend_q;
      if (en_i) clk_d = (cnt_q < high_q);
    end else if (en_i) begin
      clk_d  = (cnt_q < high_q);
      tick_d = last;
      cnt_d  = last ? '0 : cnt_q + ONE;
      apply  = last & pend_q;
    end

    if (apply) begin
      per_d  = sper_q;
      high_d = shigh_q;
      pend_d = 1'b0;
    end

    // A same-cycle accept lands after the apply:
    // old shadow goes live, new one stays pending.
    if (wr_i) begin
      sper_d  = CNT_W'(clamp_period(32'(period_i)));
      shigh_d = high_i;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      per_q   <= RST_P;
      high_q  <= RST_H;
      sper_q  <= RST_P;
      shigh_q <= RST_H;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      high_q  <= high_d;
      sper_q  <= sper_d;
      shigh_q <= shigh_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/tick_divider.sv
// tick_divider: NCH independent divided clocks with
// runtime period/high, applied at period boundaries.
// Ports: clk, rst_n (async low), en, [sync_in],
//   cfg_valid/cfg_ready/cfg_ch/cfg_period/cfg_high,
//   clk_out[NCH], tick[NCH].
// Define TICK_DIVIDER_SYNC_EN to add sync_in.
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter int          CNT_W          = 19,
  parameter int          NCH            = 4,
  parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD,
  parameter int unsigned DEFAULT_HIGH   = DEF_HIGH,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef TICK_DIVIDER_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  localparam int NSLOT = 1 << CH_W;

  logic [NCH-1:0]   pend;
  logic [NSLOT-1:0] pend_ext;
  logic             sync;
  logic             accept;

`ifdef TICK_DIVIDER_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // Unused channel slots read as not-pending, so
  // out-of-range requests are accepted and dropped.
  always_comb begin
    pend_ext          = '0;
    pend_ext[NCH-1:0] = pend;
  end

  assign cfg_ready = ~pend_ext[cfg_ch];
  assign accept    = cfg_valid & cfg_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_divider_ch #(
      .CNT_W (CNT_W),
      .DEF_P (DEFAULT_PERIOD),
      .DEF_H (DEFAULT_HIGH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en),
      .sync_i   (sync),
      .wr_i     (accept && (cfg_ch == CH_W'(i))),
      .period_i (cfg_period),
      .high_i   (cfg_high),
      .pend_o   (pend[i]),
      .clk_o    (clk_out[i]),
      .tick_o   (tick[i])
    );
  end

endmodule
